// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encoding, the sequencer state enum and operand-class helpers.
package muldiv_sequencer_pkg;

   localparam int MULDIV_ITER  = 32;
   localparam int MULDIV_CNT_W = 5;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } muldiv_state_t;

   function automatic logic op_is_div(input muldiv_op_t op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic op_is_rem(input muldiv_op_t op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   function automatic logic op_signed_a(input muldiv_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   function automatic logic op_signed_b(input muldiv_op_t op);
      return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline (master) and the muldiv unit (slave).
interface muldiv_sequencer_if;
   import muldiv_sequencer_pkg::*;

   logic        startE;
   muldiv_op_t  opE;
   logic [31:0] srcAE;
   logic [31:0] srcBE;
   logic        flushE;
   logic        busyE;
   logic        doneE;
   logic [31:0] resultE;

   modport master (
      output startE, opE, srcAE, srcBE, flushE,
      input  busyE, doneE, resultE
   );

   modport slave (
      input  startE, opE, srcAE, srcBE, flushE,
      output busyE, doneE, resultE
   );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add multiply or restoring divide.
// acc holds {product_hi, multiplier} when multiplying, {remainder, dividend/quotient} when dividing.
module muldiv_step (
   input  logic        is_div_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] opnd_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic [32:0] rem_sh;
   logic [32:0] diff;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sum    = '0;
      rem_sh = '0;
      diff   = '0;
      acc_o  = acc_i;
      if (!is_div_i) begin
         sum   = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
         acc_o = {sum, acc_i[31:1]};
      end else begin
         // A borrow out of bit 32 means the shifted remainder was below the divisor.
         rem_sh = acc_i[63:31];
         diff   = rem_sh - {1'b0, opnd_i};
         if (!diff[32]) begin
            acc_o = {diff[31:0], acc_i[30:0], 1'b1};
         end else begin
            acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the Execute stage.
// Latches magnitudes and signs on acceptance, iterates 32 times, fixes signs on completion.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   muldiv_sequencer_if.slave bus
);

   muldiv_state_t           state_q;
   logic [MULDIV_CNT_W-1:0] cnt_q;
   muldiv_op_t              op_q;
   logic [63:0]             acc_q;
   logic [31:0]             opnd_q;
   logic                    res_neg_q;
   logic                    rem_neg_q;
   logic                    done_q;
   logic [31:0]             result_q;

   logic [63:0] acc_d;
   logic [31:0] result_d;
   logic        sa, sb;
   logic [31:0] a_mag, b_mag;
   logic        in_div, div_zero, div_ovf, accept;

   assign sa       = op_signed_a(bus.opE) & bus.srcAE[31];
   assign sb       = op_signed_b(bus.opE) & bus.srcBE[31];
   assign a_mag    = sa ? -bus.srcAE : bus.srcAE;
   assign b_mag    = sb ? -bus.srcBE : bus.srcBE;
   assign in_div   = op_is_div(bus.opE);
   assign div_zero = in_div && (bus.srcBE == 32'h0);
   assign div_ovf  = (bus.opE == OP_DIV || bus.opE == OP_REM) &&
                     (bus.srcAE == 32'h8000_0000) && (bus.srcBE == 32'hFFFF_FFFF);
   assign accept   = (state_q == IDLE) && bus.startE && !bus.flushE;

   muldiv_step u_step (
      .is_div_i (op_is_div(op_q)),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_d)
   );

   // Sign fix-up applied to the value produced by the final iteration.
   logic [63:0] prod_fix;
   logic [31:0] quo_fix, rem_fix;
   always_comb begin
      prod_fix = res_neg_q ? -acc_d : acc_d;
      quo_fix  = res_neg_q ? -acc_d[31:0] : acc_d[31:0];
      rem_fix  = rem_neg_q ? -acc_d[63:32] : acc_d[63:32];
      result_d = '0;
      unique case (op_q)
         OP_MUL:                       result_d = prod_fix[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[63:32];
         OP_DIV, OP_DIVU:              result_d = quo_fix;
         OP_REM, OP_REMU:              result_d = rem_fix;
         default:                      result_d = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         op_q      <= OP_MUL;
         acc_q     <= '0;
         opnd_q    <= '0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q      <= bus.opE;
                  cnt_q     <= '0;
                  res_neg_q <= sa ^ sb;
                  rem_neg_q <= sa;
                  acc_q     <= in_div ? {32'h0, a_mag} : {32'h0, b_mag};
                  opnd_q    <= in_div ? b_mag : a_mag;
                  if (div_zero) begin
                     result_q <= op_is_rem(bus.opE) ? bus.srcAE : 32'hFFFF_FFFF;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else if (div_ovf) begin
                     result_q <= op_is_rem(bus.opE) ? 32'h0 : 32'h8000_0000;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               if (bus.flushE) begin
                  state_q <= IDLE;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + MULDIV_CNT_W'(1);
                  if (cnt_q == MULDIV_CNT_W'(MULDIV_ITER - 1)) begin
                     result_q <= result_d;
                     done_q   <= 1'b1;
                     state_q  <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busyE   = accept || (state_q == RUN);
   assign bus.doneE   = done_q;
   assign bus.resultE = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: latency, results, fast paths, flush and reset.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   muldiv_sequencer_if bus ();

   muldiv_sequencer u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      muldiv_op_t  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   // Starts one op in the current cycle, then follows it to completion and one cycle beyond.
   task automatic issue_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res, output bit busy_ok,
                           output bit timed_out, output bit one_shot);
      bit seen;
      bus.startE = 1'b1;
      bus.opE    = op;
      bus.srcAE  = a;
      bus.srcBE  = b;
      #1;
      busy_ok = (bus.busyE === 1'b1);
      @(posedge clk); #1;
      bus.startE = 1'b0;
      bus.srcAE  = 32'hDEAD_BEEF;
      bus.srcBE  = 32'h0;
      lat = 0; res = 'x; seen = 1'b0;
      for (int k = 1; k <= 100 && !seen; k++) begin
         if (bus.doneE === 1'b1) begin
            seen = 1'b1;
            lat  = k;
            res  = bus.resultE;
            if (bus.busyE !== 1'b0) busy_ok = 1'b0;
         end else begin
            if (bus.busyE !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
         end
      end
      timed_out = !seen;
      @(posedge clk); #1;
      one_shot = (bus.doneE === 1'b0);
   endtask

   task automatic run_table(input string tag, input vec_t v[]);
      int lat; logic [31:0] res; bit busy_ok, to, one;
      foreach (v[i]) begin
         issue_op(v[i].op, v[i].a, v[i].b, lat, res, busy_ok, to, one);
         n_vec++;
         if (to) begin
            n_err++;
            $display("FAIL %s[%0d] timeout: no doneE within 100 cycles, expected at T+%0d", tag, i, v[i].lat);
         end else begin
            if (res !== v[i].exp) begin
               n_err++;
               $display("FAIL %s[%0d] result: got %h expected %h", tag, i, res, v[i].exp);
            end
            n_vec++;
            if (lat !== v[i].lat) begin
               n_err++;
               $display("FAIL %s[%0d] latency: got T+%0d expected T+%0d", tag, i, lat, v[i].lat);
            end
         end
         n_vec++;
         if (!busy_ok) begin
            n_err++;
            $display("FAIL %s[%0d] busyE: pattern wrong, expected 1 through RUN and 0 in DONE", tag, i);
         end
         n_vec++;
         if (!one) begin
            n_err++;
            $display("FAIL %s[%0d] doneE one-shot: got 1 after DONE, expected 0", tag, i);
         end
      end
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.startE = 1'b0;
      bus.opE    = OP_MUL;
      bus.srcAE  = '0;
      bus.srcBE  = '0;
      bus.flushE = 1'b0;
      #3;
      n_vec++;
      if (bus.doneE !== 1'b0) begin n_err++; $display("FAIL reset doneE: got %b expected 0", bus.doneE); end
      n_vec++;
      if (bus.resultE !== 32'h0) begin n_err++; $display("FAIL reset resultE: got %h expected 00000000", bus.resultE); end
      n_vec++;
      if (bus.busyE !== 1'b0) begin n_err++; $display("FAIL reset busyE idle: got %b expected 0", bus.busyE); end
      bus.startE = 1'b1;
      #1;
      n_vec++;
      if (bus.busyE !== 1'b1) begin n_err++; $display("FAIL reset busyE with startE: got %b expected 1", bus.busyE); end
      bus.startE = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
      vec_t v[];
      v = new[5];
      v[0] = '{OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      v[1] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      v[2] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      v[3] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      v[4] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      run_table("mul", v);
   endtask

   task automatic test_div();
      vec_t v[];
      v = new[7];
      v[0] = '{OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
      v[1] = '{OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
      v[2] = '{OP_DIVU, 32'd100,       32'd7,         32'd14,        33};
      v[3] = '{OP_REMU, 32'd100,       32'd7,         32'd2,         33};
      v[4] = '{OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      v[5] = '{OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};
      v[6] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      run_table("div", v);
   endtask

   task automatic test_div_fast();
      vec_t v[];
      v = new[6];
      v[0] = '{OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      v[1] = '{OP_REMU, 32'd5,         32'd0,         32'd5,         1};
      v[2] = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      v[3] = '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      v[4] = '{OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1};
      v[5] = '{OP_REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
      run_table("fast", v);
   endtask

   task automatic test_back_to_back();
      int k; bit seen;
      bus.startE = 1'b1; bus.opE = OP_MULHU;
      bus.srcAE  = 32'hFFFF_FFFF; bus.srcBE = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      // startE stays high with a different op; it must be ignored until IDLE.
      bus.opE = OP_DIV; bus.srcAE = 32'h0; bus.srcBE = 32'h0;
      seen = 1'b0; k = 1;
      while (k <= 100 && !seen) begin
         if (bus.doneE === 1'b1) seen = 1'b1;
         else begin @(posedge clk); #1; k++; end
      end
      n_vec++;
      if (!seen || k != 33) begin
         n_err++; $display("FAIL b2b first latency: got T+%0d (seen=%b) expected T+33", k, seen);
      end
      n_vec++;
      if (bus.resultE !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b first result: got %h expected fffffffe", bus.resultE); end
      n_vec++;
      if (bus.busyE !== 1'b0) begin n_err++; $display("FAIL b2b busyE in DONE: got %b expected 0", bus.busyE); end
      @(posedge clk); #1;
      n_vec++;
      if (bus.busyE !== 1'b1 || bus.doneE !== 1'b0) begin
         n_err++; $display("FAIL b2b idle accept: got busy=%b done=%b expected busy=1 done=0", bus.busyE, bus.doneE);
      end
      @(posedge clk); #1;
      bus.startE = 1'b0;
      n_vec++;
      if (bus.doneE !== 1'b1 || bus.resultE !== 32'hFFFF_FFFF) begin
         n_err++; $display("FAIL b2b second op: got done=%b result=%h expected done=1 result=ffffffff", bus.doneE, bus.resultE);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int lat; logic [31:0] res; bit busy_ok, to, one, stray;
      bus.startE = 1'b1; bus.opE = OP_DIVU; bus.srcAE = 32'd1000; bus.srcBE = 32'd3;
      @(posedge clk); #1;
      bus.startE = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      n_vec++;
      if (bus.busyE !== 1'b1) begin n_err++; $display("FAIL flush pre busyE: got %b expected 1", bus.busyE); end
      bus.flushE = 1'b1;
      @(posedge clk); #1;
      bus.flushE = 1'b0;
      n_vec++;
      if (bus.busyE !== 1'b0 || bus.doneE !== 1'b0) begin
         n_err++; $display("FAIL flush idle: got busy=%b done=%b expected busy=0 done=0", bus.busyE, bus.doneE);
      end
      stray = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.doneE !== 1'b0) stray = 1'b1;
         @(posedge clk); #1;
      end
      n_vec++;
      if (stray) begin n_err++; $display("FAIL flush stray doneE: got 1 after flush expected 0"); end
      issue_op(OP_MUL, 32'd3, 32'd4, lat, res, busy_ok, to, one);
      n_vec++;
      if (to || res !== 32'd12 || lat != 33) begin
         n_err++; $display("FAIL flush followup MUL: got result %h lat %0d timeout %b expected 0000000c lat 33", res, lat, to);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] res; bit busy_ok, to, one, stray;
      bus.startE = 1'b1; bus.opE = OP_MUL; bus.srcAE = 32'd5; bus.srcBE = 32'd6;
      @(posedge clk); #1;
      bus.startE = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      n_vec++;
      if (bus.resultE !== 32'h0 || bus.doneE !== 1'b0 || bus.busyE !== 1'b0) begin
         n_err++; $display("FAIL midreset state: got result=%h done=%b busy=%b expected 00000000/0/0", bus.resultE, bus.doneE, bus.busyE);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      stray = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.doneE !== 1'b0) stray = 1'b1;
         @(posedge clk); #1;
      end
      n_vec++;
      if (stray) begin n_err++; $display("FAIL midreset stray doneE: got 1 after release expected 0"); end
      issue_op(OP_DIVU, 32'd100, 32'd7, lat, res, busy_ok, to, one);
      n_vec++;
      if (to || res !== 32'd14 || lat != 33) begin
         n_err++; $display("FAIL midreset followup DIVU: got result %h lat %0d timeout %b expected 0000000e lat 33", res, lat, to);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_mul();
      test_div();
      test_div_fast();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
